// File: rtl/bit_serial_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
// The FSM state encoding and the digit-counter width rule live here.
package bit_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int num_digits(input int n, input int w);
    return n / w;
  endfunction

  // A single-digit configuration still needs a one-bit counter.
  function automatic int cnt_width(input int ndig);
    return ($clog2(ndig) < 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/bit_serial_adder_digit.sv
// Combinational W-bit ripple full-adder slice, the add-direction mirror of
// the subtractor's borrow chain. Also exposes the carry into the top bit.
module digit_adder #(
  parameter int W = 1
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] z,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  always_comb begin
    logic [W:0] c;
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      s[i]   = x[i] ^ z[i] ^ c[i];
      c[i+1] = (x[i] & z[i]) | (x[i] & c[i]) | (z[i] & c[i]);
    end
    co       = c[W];
    c_msb_in = c[W-1];
  end

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-cycle N-bit adder: y = a + b + cin, W bits per clock, with
// valid/ready handshakes on both the operand and the result side.
module bit_serial_adder
  import bit_serial_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic         cout,
  output logic         ovf
);

  localparam int NDIG = num_digits(N, W);
  localparam int CW   = cnt_width(NDIG);

  if ((W < 1) || (N % W != 0)) begin : g_bad_digit_width
    $error("bit_serial_adder: W must divide N");
  end

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   y_q, y_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           out_valid_q, out_valid_d;
  logic           in_ready_q, in_ready_d;

  logic [W-1:0]   dig_sum;
  logic           dig_co;
  logic           dig_c_msb;
  logic           last_digit;

  digit_adder #(.W(W)) u_digit (
    .x        (a_q[W-1:0]),
    .z        (b_q[W-1:0]),
    .ci       (carry_q),
    .s        (dig_sum),
    .co       (dig_co),
    .c_msb_in (dig_c_msb)
  );

  assign last_digit = (cnt_q == CW'(NDIG - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    y_d         = y_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          carry_d    = cin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end

      RUN: begin
        // The digit lands at its final position so y never needs realigning.
        y_d[int'(cnt_q)*W +: W] = dig_sum;
        carry_d = dig_co;
        a_d     = a_q >> W;
        b_d     = b_q >> W;
        cnt_d   = cnt_q + CW'(1);
        if (last_digit) begin
          cout_d      = dig_co;
          ovf_d       = dig_c_msb ^ dig_co;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      y_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      y_q         <= y_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and randomized checks of bit_serial_adder with W=1 and W=4,
// covering latency, carry/overflow corners, backpressure and async reset.
module tb_bit_serial_adder;

  logic       clk;
  logic       rst;
  logic [7:0] a_in, b_in;
  logic       cin_in;

  logic       iv1, ir1, ov1, or1, cout1, ovf1;
  logic [7:0] y1;
  logic       iv4, ir4, ov4, or4, cout4, ovf4;
  logic [7:0] y4;

  int tests;
  int failed;

  bit_serial_adder #(.N(8), .W(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .a(a_in), .b(b_in), .cin(cin_in),
    .out_valid(ov1), .out_ready(or1), .y(y1), .cout(cout1), .ovf(ovf1)
  );

  bit_serial_adder #(.N(8), .W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
    .a(a_in), .b(b_in), .cin(cin_in),
    .out_valid(ov4), .out_ready(or4), .y(y4), .cout(cout4), .ovf(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] y;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[8];

  function automatic logic rdy(input bit sel);
    return sel ? ir4 : ir1;
  endfunction

  function automatic logic vld(input bit sel);
    return sel ? ov4 : ov1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation with out_ready held high; returns result and latency.
  task automatic do_op(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                       input logic cv, output logic [7:0] yv, output logic cov,
                       output logic ovv, output int lat);
    chk("in_ready_before_accept", 32'(rdy(sel)), 32'd1);
    a_in = av; b_in = bv; cin_in = cv;
    if (sel) begin iv4 = 1'b1; or4 = 1'b1; end
    else     begin iv1 = 1'b1; or1 = 1'b1; end
    tick();
    iv1 = 1'b0; iv4 = 1'b0;
    a_in = ~av; b_in = ~bv; cin_in = ~cv;
    chk("in_ready_after_accept", 32'(rdy(sel)), 32'd0);
    lat = 0;
    while (!vld(sel) && lat < 64) begin
      tick();
      lat++;
    end
    yv  = sel ? y4 : y1;
    cov = sel ? cout4 : cout1;
    ovv = sel ? ovf4 : ovf1;
    tick();
    chk("out_valid_drop", 32'(vld(sel)), 32'd0);
  endtask

  task automatic run_vec(input bit sel, input int ndig, input vec_t v);
    logic [7:0] yv;
    logic       cov, ovv;
    int         lat;
    do_op(sel, v.a, v.b, v.cin, yv, cov, ovv, lat);
    chk("latency", 32'(lat), 32'(ndig));
    chk("y", 32'(yv), 32'(v.y));
    chk("cout", 32'(cov), 32'(v.cout));
    chk("ovf", 32'(ovv), 32'(v.ovf));
    $display("[TB] W=%0d %02h + %02h + %0d -> y=%02h cout=%0d ovf=%0d lat=%0d",
             sel ? 4 : 1, v.a, v.b, v.cin, yv, cov, ovv, lat);
  endtask

  initial begin
    logic [7:0] yv;
    logic       cov, ovv;
    int         lat;
    int         cyc;
    bit         seen;

    tests = 0; failed = 0;
    rst = 1'b1;
    a_in = '0; b_in = '0; cin_in = 1'b0;
    iv1 = 1'b0; or1 = 1'b0; iv4 = 1'b0; or4 = 1'b0;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[6] = '{8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'hA5, 8'h5B, 1'b1, 8'h01, 1'b1, 1'b0};

    repeat (2) tick();
    chk("reset_y", 32'(y1), 32'h0);
    chk("reset_cout", 32'(cout1), 32'h0);
    chk("reset_ovf", 32'(ovf1), 32'h0);
    chk("reset_out_valid", 32'(ov1), 32'h0);
    chk("reset_in_ready", 32'(ir1), 32'h1);
    chk("reset_in_ready_w4", 32'(ir4), 32'h1);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(1'b0, 8, vecs[i]);
    foreach (vecs[i]) run_vec(1'b1, 2, vecs[i]);

    // Backpressure: result must hold and a stray in_valid must be ignored.
    or1 = 1'b0;
    a_in = 8'h12; b_in = 8'h34; cin_in = 1'b0; iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    cyc = 0;
    while (!ov1 && cyc < 64) begin tick(); cyc++; end
    chk("bp_latency", 32'(cyc), 32'd8);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin a_in = 8'hFF; b_in = 8'hFF; iv1 = 1'b1; end
      else iv1 = 1'b0;
      chk("bp_y_hold", 32'(y1), 32'h46);
      chk("bp_out_valid", 32'(ov1), 32'h1);
      chk("bp_in_ready", 32'(ir1), 32'h0);
      tick();
    end
    iv1 = 1'b0;
    or1 = 1'b1;
    tick();
    chk("bp_release_out_valid", 32'(ov1), 32'h0);
    chk("bp_release_in_ready", 32'(ir1), 32'h1);
    chk("bp_release_y_kept", 32'(y1), 32'h46);
    tick();
    chk("bp_no_capture", 32'(ir1), 32'h1);
    $display("[TB] W=1 backpressure 12 + 34 -> y=%02h held 5 cycles", y1);

    // Asynchronous reset three cycles into RUN.
    a_in = 8'h55; b_in = 8'h22; cin_in = 1'b0; iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_y", 32'(y1), 32'h0);
    chk("rst_mid_out_valid", 32'(ov1), 32'h0);
    chk("rst_mid_in_ready", 32'(ir1), 32'h1);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (ov1) seen = 1'b1;
      tick();
    end
    chk("rst_no_result", 32'(seen), 32'h0);
    do_op(1'b0, 8'h01, 8'h01, 1'b0, yv, cov, ovv, lat);
    chk("post_rst_y", 32'(yv), 32'h02);
    chk("post_rst_latency", 32'(lat), 32'd8);
    $display("[TB] W=1 reset mid-run, then 01 + 01 -> y=%02h", yv);

    // Randomized regression on the W=4 instance with handshake stalls.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      logic [8:0] sum;
      logic       exp_ovf;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      sum = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      exp_ovf = (ra[7] == rb[7]) && (sum[7] != ra[7]);
      repeat ($urandom_range(0, 2)) tick();
      a_in = ra; b_in = rb; cin_in = rc; iv4 = 1'b1;
      or4 = 1'($urandom);
      tick();
      iv4 = 1'b0;
      a_in = 8'($urandom); b_in = 8'($urandom);
      cyc = 0;
      while (!ov4 && cyc < 64) begin
        or4 = 1'($urandom);
        iv4 = 1'($urandom);
        tick();
        cyc++;
      end
      or4 = 1'b0;
      iv4 = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      chk("rand_result", {20'b0, ov4, cout4, ovf4, 1'b0, y4},
          {20'b0, 1'b1, sum[8], exp_ovf, 1'b0, sum[7:0]});
      or4 = 1'b1;
      tick();
      or4 = 1'b0;
    end
    $display("[TB] W=4 random regression of 1000 operations complete");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Multi-cycle N-bit adder, the add-direction counterpart of the team's ripple N-bit subtractor. Computes y = a + b + cin, W bits per clock.
- Operands enter through a valid/ready handshake. The result leaves through a second valid/ready handshake.
- Used where area matters more than latency, e.g. accumulators and address arithmetic in slow control paths.

Parameters:
- N, 8, operand and result width in bits.
- W, 1, digit width processed per cycle. Must divide N; elaboration fails otherwise.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands.
- a  input  N  augend.
- b  input  N  addend.
- cin  input  1  carry in.
- out_valid  output  1  y, cout, ovf are valid.
- out_ready  input  1  consumer accepts the result.
- y  output  N  sum, modulo 2^N.
- cout  output  1  unsigned carry out of the MSB.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async assert, any state):
  - state = IDLE, digit counter = 0, carry reg = 0.
  - a/b shift regs = 0.
  - y = 0, cout = 0, ovf = 0, out_valid = 0, in_ready = 1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On an edge with in_valid=1, capture a and b into shift regs, cin into the carry reg, clear the counter, go to RUN.
  - Operands are sampled only on this accept edge; later input changes are ignored.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each edge: the low W bits of the a/b regs plus the carry reg form one W-bit ripple sum.
  - The sum digit is written into y position counter*W. The carry reg takes the digit carry-out. The a/b regs shift right by W. The counter increments.
  - On the edge where counter = N/W-1:
    - last digit written;
    - cout = final carry;
    - ovf = carry-into-MSB XOR final carry;
    - go to DONE.
- Latency: out_valid rises exactly N/W cycles after the accept edge (N=8, W=1: 8 cycles; W=4: 2 cycles).
- DONE:
  - out_valid = 1, in_ready = 0.
  - y, cout and ovf are held stable while out_ready = 0 (unbounded backpressure).
  - On an edge with out_ready=1, go to IDLE. out_valid drops the next cycle; y/cout/ovf keep their last values until the next run overwrites them.
- Throughput: one operation per N/W + 2 cycles minimum. The block does not accept new operands in the same cycle a result is taken (no overlap).
- in_valid in RUN/DONE: ignored, not captured. The source must hold it until in_ready.
- out_ready outside DONE: ignored.
- Reset mid-RUN or mid-DONE: the operation is discarded and no result is issued. After reset release the block is in IDLE with in_ready=1.
- Arithmetic: y is modulo 2^N. cout is the true unsigned carry-out. cin=1 together with a=b=all-ones gives y=all-ones, cout=1.

Decomposition:
- Shared package (bit_serial_pkg): state enum {IDLE, RUN, DONE}; localparam NDIG = N/W; counter width $clog2(NDIG) with a minimum of 1.
- Sub-module digit_adder: combinational W-bit ripple full-adder slice.
  - Inputs: x[W], z[W], ci.
  - Outputs: s[W], co, c_msb_in (carry into bit W-1).
  - The top level instantiates it once; it is the structural mirror of the subtractor's borrow chain.

Test Plan:
- N=8, W=1: a=0x5A, b=0x3C, cin=0, out_ready=1 -> out_valid 8 cycles after accept; y=0x96, cout=0, ovf=1.
- N=8, W=1: a=0xFF, b=0x01, cin=0 -> y=0x00, cout=1, ovf=0. Then a=0xFF, b=0xFF, cin=1 -> y=0xFF, cout=1, ovf=0.
- N=8, W=1: a=0x7F, b=0x01, cin=0 -> y=0x80, cout=0, ovf=1. a=0x80, b=0x80 -> y=0x00, cout=1, ovf=1.
- Backpressure: a=0x12, b=0x34, out_ready held 0 for 5 cycles in DONE -> y=0x46 stable, out_valid=1, in_ready=0 throughout. in_valid pulsed with new operands is not captured. Raising out_ready -> IDLE next edge.
- Reset: assert rst asynchronously 3 cycles into RUN -> y=0, out_valid=0, in_ready=1 immediately. No result for that operation. The next operation, 0x01+0x01, gives y=0x02.
- N=8, W=4: a=0xA5, b=0x5B, cin=1 -> out_valid 2 cycles after accept; y=0x01, cout=1, ovf=0. Random 1000-op regression against a + b + cin, with random in_valid/out_ready stalls.
